to_ip_tx_noc_out_ctrl: RTL and testbench
========================================

TO_IP_TX_NOC_OUT_CTRL -- requirements
Module: to_ip_tx_noc_out_ctrl

Interface
REQ-001 Parameters: none; flit byte width is `NOC_DATA_BYTES (2^`NOC_DATA_BYTES_W).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 src_to_ip_tx_out_meta_val  input  1  source header/metadata valid.
REQ-005 to_ip_tx_out_src_meta_rdy  output  1  metadata accepted.
REQ-006 src_to_ip_tx_out_payload_len  input  `TOT_LEN_W  payload byte count; qualified by meta_val.
REQ-007 src_to_ip_tx_out_data_val  input  1  source data beat valid.
REQ-008 to_ip_tx_out_src_data_rdy  output  1  data beat accepted.
REQ-009 to_ip_tx_out_noc0_val  output  1  NoC flit valid.
REQ-010 noc0_to_ip_tx_out_rdy  input  1  NoC ready.
REQ-011 ctrl_datap_flit_sel  output  to_ip_tx_pkg::noc_flit_mux_sel  SEL_HDR_FLIT / SEL_META_FLIT / SEL_DATA_FLIT.
REQ-012 ctrl_datap_store_inputs  output  1  datapath captures header fields.
REQ-013 datap_ctrl_last_output  input  1  current data beat is last of packet.
REQ-014 ctrl_len_err  output  1  sticky: data beat count disagreed with payload_len.

Function
REQ-015 FSM states: READY, META, DATA; one-hot or encoded, implementer's choice.
REQ-016 READY: flit_sel=HDR; noc0_val=meta_val; store_inputs=meta_val; meta_rdy=noc0_rdy; data_rdy=0.
REQ-017 READY, meta_val&noc0_rdy: header flit transferred, metadata consumed same cycle; exp_flits captured = ceil(payload_len/`NOC_DATA_BYTES) (low bits nonzero -> +1); beat counter cleared to 0; -> META.
REQ-018 READY, meta_val&!noc0_rdy: remain READY; meta_rdy=0; source holds inputs stable.
REQ-019 META: flit_sel=META; noc0_val=1; store_inputs=0; meta_rdy=0; data_rdy=0.
REQ-020 META, noc0_rdy: exp_flits==0 -> READY (no data flits); else -> DATA. !noc0_rdy: hold.
REQ-021 DATA: flit_sel=DATA; noc0_val=data_val; data_rdy=noc0_rdy; meta_rdy=0; store_inputs=0.
REQ-022 DATA beat handshake = data_val&noc0_rdy; each increments beat counter (width `MSG_LENGTH_WIDTH, saturates at max).
REQ-023 DATA, beat with datap_ctrl_last_output=1 -> READY; no other DATA exit.
REQ-024 On last beat: if (counter+1)!=exp_flits, set ctrl_len_err; stays set until rst.
REQ-025 Non-last beat completing count (counter+1==exp_flits): set ctrl_len_err, stay DATA until last.
REQ-026 Data beats never accepted outside DATA; metadata never accepted outside READY.
REQ-027 Latency: hdr flit same cycle as meta handshake; meta flit earliest next cycle; first data flit earliest cycle after meta flit; back-to-back packets without bubble from last beat to next header (READY entered cycle after last).
REQ-028 noc0_val, once asserted in META, held until noc0_rdy (no retraction).
REQ-029 Simultaneous meta_val and data_val in READY: only metadata considered.

Reset
REQ-030 rst high: state<=READY, counter<=0, exp_flits<=0, ctrl_len_err<=0.
REQ-031 While rst high: noc0_val, meta_rdy, data_rdy, store_inputs forced 0; flit_sel=HDR.
REQ-032 rst mid-packet (META or DATA): partial packet abandoned; READY next cycle; no flit emitted in reset cycle.

Verification (64-byte flits)
REQ-033 payload_len=128, noc0_rdy=1, data always valid, last on beat 2 -> hdr, meta, 2 data flits on 4 consecutive cycles; ctrl_len_err=0.
REQ-034 payload_len=0 -> hdr, meta only; FSM READY after meta; data_rdy never 1.
REQ-035 payload_len=65, last on beat 2; noc0_rdy low 3 cycles during META -> meta flit held stable with val=1; 2 data flits; no error.
REQ-036 payload_len=128, last asserted on beat 1 -> return READY; ctrl_len_err=1 until rst.
REQ-037 Two packets back-to-back (len 64 each) -> 6 flits, 6 consecutive cycles, second hdr cycle after first last beat.
REQ-038 rst asserted during DATA beat 1 of len 192 -> outputs 0 that cycle; next meta_val starts clean packet with correct hdr.

Source files
------------

// File: rtl/to_ip_tx_noc_out_ctrl_if.sv
// Flit-type package and handshake bundle for the TX NoC output controller.
// Width macros default to 64-byte flits when the including build does not set them.
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef NOC_DATA_BYTES
`define NOC_DATA_BYTES (2 ** `NOC_DATA_BYTES_W)
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

package to_ip_tx_pkg;
  typedef enum logic [1:0] {
    SEL_HDR_FLIT  = 2'd0,
    SEL_META_FLIT = 2'd1,
    SEL_DATA_FLIT = 2'd2
  } noc_flit_mux_sel;
endpackage

interface to_ip_tx_noc_out_ctrl_if;
  logic                              src_to_ip_tx_out_meta_val;
  logic                              to_ip_tx_out_src_meta_rdy;
  logic [`TOT_LEN_W-1:0]             src_to_ip_tx_out_payload_len;
  logic                              src_to_ip_tx_out_data_val;
  logic                              to_ip_tx_out_src_data_rdy;
  logic                              to_ip_tx_out_noc0_val;
  logic                              noc0_to_ip_tx_out_rdy;
  to_ip_tx_pkg::noc_flit_mux_sel     ctrl_datap_flit_sel;
  logic                              ctrl_datap_store_inputs;
  logic                              datap_ctrl_last_output;
  logic                              ctrl_len_err;

  // Controller side
  modport master (
    input  src_to_ip_tx_out_meta_val,
    output to_ip_tx_out_src_meta_rdy,
    input  src_to_ip_tx_out_payload_len,
    input  src_to_ip_tx_out_data_val,
    output to_ip_tx_out_src_data_rdy,
    output to_ip_tx_out_noc0_val,
    input  noc0_to_ip_tx_out_rdy,
    output ctrl_datap_flit_sel,
    output ctrl_datap_store_inputs,
    input  datap_ctrl_last_output,
    output ctrl_len_err
  );

  // Source / NoC / datapath side
  modport slave (
    output src_to_ip_tx_out_meta_val,
    input  to_ip_tx_out_src_meta_rdy,
    output src_to_ip_tx_out_payload_len,
    output src_to_ip_tx_out_data_val,
    input  to_ip_tx_out_src_data_rdy,
    input  to_ip_tx_out_noc0_val,
    output noc0_to_ip_tx_out_rdy,
    input  ctrl_datap_flit_sel,
    input  ctrl_datap_store_inputs,
    output datap_ctrl_last_output,
    input  ctrl_len_err
  );
endinterface

// File: rtl/to_ip_tx_noc_out_ctrl.sv
// TX NoC output sequencer: emits header, metadata, then payload flits per packet,
// and flags a sticky error when the data beat count disagrees with payload_len.
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

module to_ip_tx_noc_out_ctrl (
  input  logic                          clk,
  input  logic                          rst,
  to_ip_tx_noc_out_ctrl_if.master       bus
);
  import to_ip_tx_pkg::*;

  localparam int LEN_W = `TOT_LEN_W;
  localparam int BW    = `NOC_DATA_BYTES_W;
  localparam int CNT_W = `MSG_LENGTH_WIDTH;
  localparam int EXP_W = LEN_W - BW + 1;
  localparam int CMP_W = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

  typedef enum logic [1:0] {ST_READY, ST_META, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [EXP_W-1:0]   exp_flits_q, exp_flits_d;
  logic               len_err_q, len_err_d;

  logic               meta_hs, data_hs, cnt_done;
  logic [CMP_W-1:0]   cnt_plus1;

  assign meta_hs   = bus.src_to_ip_tx_out_meta_val & bus.noc0_to_ip_tx_out_rdy;
  assign data_hs   = bus.src_to_ip_tx_out_data_val & bus.noc0_to_ip_tx_out_rdy;
  // Widened so a saturated counter still compares correctly against exp_flits
  assign cnt_plus1 = CMP_W'(beat_cnt_q) + CMP_W'(1);
  assign cnt_done  = (cnt_plus1 == CMP_W'(exp_flits_q));

  always_comb begin
    state_d                     = state_q;
    beat_cnt_d                  = beat_cnt_q;
    exp_flits_d                 = exp_flits_q;
    len_err_d                   = len_err_q;
    bus.ctrl_datap_flit_sel     = SEL_HDR_FLIT;
    bus.to_ip_tx_out_noc0_val   = 1'b0;
    bus.to_ip_tx_out_src_meta_rdy = 1'b0;
    bus.to_ip_tx_out_src_data_rdy = 1'b0;
    bus.ctrl_datap_store_inputs = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_READY: begin
          bus.to_ip_tx_out_noc0_val     = bus.src_to_ip_tx_out_meta_val;
          bus.ctrl_datap_store_inputs   = bus.src_to_ip_tx_out_meta_val;
          bus.to_ip_tx_out_src_meta_rdy = bus.noc0_to_ip_tx_out_rdy;
          if (meta_hs) begin
            // Round partial trailing flit up to a whole flit
            exp_flits_d = EXP_W'(bus.src_to_ip_tx_out_payload_len >> BW)
                        + EXP_W'(|bus.src_to_ip_tx_out_payload_len[BW-1:0]);
            beat_cnt_d  = '0;
            state_d     = ST_META;
          end
        end
        ST_META: begin
          bus.ctrl_datap_flit_sel   = SEL_META_FLIT;
          bus.to_ip_tx_out_noc0_val = 1'b1;
          if (bus.noc0_to_ip_tx_out_rdy) begin
            state_d = (exp_flits_q == '0) ? ST_READY : ST_DATA;
          end
        end
        ST_DATA: begin
          bus.ctrl_datap_flit_sel       = SEL_DATA_FLIT;
          bus.to_ip_tx_out_noc0_val     = bus.src_to_ip_tx_out_data_val;
          bus.to_ip_tx_out_src_data_rdy = bus.noc0_to_ip_tx_out_rdy;
          if (data_hs) begin
            beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
            if (bus.datap_ctrl_last_output) begin
              state_d = ST_READY;
              if (!cnt_done) len_err_d = 1'b1;
            end else if (cnt_done) begin
              len_err_d = 1'b1;
            end
          end
        end
        default: state_d = ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_READY;
      beat_cnt_q  <= '0;
      exp_flits_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_flits_q <= exp_flits_d;
      len_err_q   <= len_err_d;
    end
  end

  assign bus.ctrl_len_err = len_err_q;

endmodule

// File: tb/tb_to_ip_tx_noc_out_ctrl.sv
// Directed bench for the TX NoC output controller; each cycle's outputs are
// compared as one packed vector against hand-derived values.
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

module tb_to_ip_tx_noc_out_ctrl;
  import to_ip_tx_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  to_ip_tx_noc_out_ctrl_if bus_if ();

  to_ip_tx_noc_out_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {noc0_val, flit_sel[1:0], meta_rdy, data_rdy, store_inputs, len_err}
  function automatic logic [6:0] obs_vec();
    return {bus_if.to_ip_tx_out_noc0_val, bus_if.ctrl_datap_flit_sel,
            bus_if.to_ip_tx_out_src_meta_rdy, bus_if.to_ip_tx_out_src_data_rdy,
            bus_if.ctrl_datap_store_inputs, bus_if.ctrl_len_err};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic r, input logic mv, input int len,
                     input logic dv, input logic last, input logic nrdy,
                     input logic [6:0] exp);
    rst                                 = r;
    bus_if.src_to_ip_tx_out_meta_val    = mv;
    bus_if.src_to_ip_tx_out_payload_len = `TOT_LEN_W'(len);
    bus_if.src_to_ip_tx_out_data_val    = dv;
    bus_if.datap_ctrl_last_output       = last;
    bus_if.noc0_to_ip_tx_out_rdy        = nrdy;
    @(negedge clk);
    check(tag, obs_vec(), exp);
    @(posedge clk);
    #1;
  endtask

  // Expected vectors for the common cases (err bit supplied separately)
  function automatic logic [6:0] v_hdr(input logic e);
    return {1'b1, SEL_HDR_FLIT, 1'b1, 1'b0, 1'b1, e};
  endfunction
  function automatic logic [6:0] v_meta(input logic e);
    return {1'b1, SEL_META_FLIT, 1'b0, 1'b0, 1'b0, e};
  endfunction
  function automatic logic [6:0] v_data(input logic e);
    return {1'b1, SEL_DATA_FLIT, 1'b0, 1'b1, 1'b0, e};
  endfunction
  function automatic logic [6:0] v_idle(input logic e);
    return {1'b0, SEL_HDR_FLIT, 1'b1, 1'b0, 1'b0, e};
  endfunction
  function automatic logic [6:0] v_rst(input logic e);
    return {1'b0, SEL_HDR_FLIT, 1'b0, 1'b0, 1'b0, e};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.src_to_ip_tx_out_meta_val    = 1'b0;
    bus_if.src_to_ip_tx_out_payload_len = '0;
    bus_if.src_to_ip_tx_out_data_val    = 1'b0;
    bus_if.datap_ctrl_last_output       = 1'b0;
    bus_if.noc0_to_ip_tx_out_rdy        = 1'b0;
    @(posedge clk); #1;

    // Reset forces handshakes low even with every input active
    cyc("rst_all_in_high", 1, 1, 128, 1, 1, 1, v_rst(0));

    // len 128: hdr, meta, 2 data flits on consecutive cycles
    cyc("p128_hdr",   0, 1, 128, 1, 0, 1, v_hdr(0));
    cyc("p128_meta",  0, 0, 0,   1, 0, 1, v_meta(0));
    cyc("p128_d1",    0, 0, 0,   1, 0, 1, v_data(0));
    cyc("p128_d2",    0, 0, 0,   1, 1, 1, v_data(0));
    cyc("p128_idle",  0, 0, 0,   0, 0, 1, v_idle(0));

    // len 0: no data phase, data_val ignored in READY
    cyc("p0_hdr",     0, 1, 0, 1, 0, 1, v_hdr(0));
    cyc("p0_meta",    0, 0, 0, 1, 0, 1, v_meta(0));
    cyc("p0_ready",   0, 0, 0, 1, 0, 1, v_idle(0));

    // READY with NoC stalled: header offered, metadata not accepted
    cyc("hdr_stall",  0, 1, 65, 0, 0, 0, {1'b1, SEL_HDR_FLIT, 1'b0, 1'b0, 1'b1, 1'b0});

    // len 65 rounds up to 2 flits; meta flit held across 3 stall cycles
    cyc("p65_hdr",    0, 1, 65, 0, 0, 1, v_hdr(0));
    for (int i = 0; i < 3; i++)
      cyc("p65_meta_stall", 0, 0, 0, 0, 0, 0, v_meta(0));
    cyc("p65_meta",   0, 0, 0, 0, 0, 1, v_meta(0));
    cyc("p65_dgap",   0, 0, 0, 0, 0, 1, {1'b0, SEL_DATA_FLIT, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc("p65_d1",     0, 0, 0, 1, 0, 1, v_data(0));
    cyc("p65_d2",     0, 0, 0, 1, 1, 1, v_data(0));
    cyc("p65_idle",   0, 0, 0, 0, 0, 1, v_idle(0));

    // Two len-64 packets back to back: 6 flits on 6 cycles
    cyc("b2b_hdr_a",  0, 1, 64, 0, 0, 1, v_hdr(0));
    cyc("b2b_meta_a", 0, 0, 0,  1, 0, 1, v_meta(0));
    cyc("b2b_d_a",    0, 1, 64, 1, 1, 1, v_data(0));
    cyc("b2b_hdr_b",  0, 1, 64, 0, 0, 1, v_hdr(0));
    cyc("b2b_meta_b", 0, 0, 0,  1, 0, 1, v_meta(0));
    cyc("b2b_d_b",    0, 0, 0,  1, 1, 1, v_data(0));
    cyc("b2b_idle",   0, 0, 0,  0, 0, 1, v_idle(0));

    // Reset during first data beat of a len-192 packet, then a clean len-64 packet
    cyc("p192_hdr",   0, 1, 192, 0, 0, 1, v_hdr(0));
    cyc("p192_meta",  0, 0, 0,   1, 0, 1, v_meta(0));
    cyc("p192_rst",   1, 0, 0,   1, 0, 1, v_rst(0));
    cyc("post_hdr",   0, 1, 64,  0, 0, 1, v_hdr(0));
    cyc("post_meta",  0, 0, 0,   1, 0, 1, v_meta(0));
    cyc("post_d1",    0, 0, 0,   1, 1, 1, v_data(0));
    cyc("post_idle",  0, 0, 0,   0, 0, 1, v_idle(0));

    // len 64 with last withheld: count completes early, stay in DATA until last
    cyc("early_hdr",  0, 1, 64, 0, 0, 1, v_hdr(0));
    cyc("early_meta", 0, 0, 0,  1, 0, 1, v_meta(0));
    cyc("early_d1",   0, 0, 0,  1, 0, 1, v_data(0));
    cyc("early_d2",   0, 0, 0,  1, 1, 1, v_data(1));
    cyc("early_idle", 0, 0, 0,  0, 0, 1, v_idle(1));
    cyc("clr_rst",    1, 0, 0,  0, 0, 1, v_rst(1));
    cyc("clr_idle",   0, 0, 0,  0, 0, 1, v_idle(0));

    // len 128 but last on beat 1: short packet, sticky error until reset
    cyc("short_hdr",  0, 1, 128, 0, 0, 1, v_hdr(0));
    cyc("short_meta", 0, 0, 0,   1, 0, 1, v_meta(0));
    cyc("short_d1",   0, 0, 0,   1, 1, 1, v_data(0));
    cyc("short_err1", 0, 0, 0,   0, 0, 1, v_idle(1));
    cyc("sticky_hdr", 0, 1, 64,  0, 0, 1, v_hdr(1));
    cyc("sticky_meta",0, 0, 0,   1, 0, 1, v_meta(1));
    cyc("sticky_d1",  0, 0, 0,   1, 1, 1, v_data(1));
    cyc("sticky_rst", 1, 0, 0,   0, 0, 1, v_rst(1));
    cyc("sticky_clr", 0, 0, 0,   0, 0, 1, v_idle(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
